// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for the auto-select 4:1 multiplexer.
//   DATA_WIDTH : default operand word width
//   NUM_INPUTS : number of operand words rotated through
//   sel_t      : select index type (0 selects input_1)
//   data_t     : operand word type at the default width
package mux_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_INPUTS = 4;

    typedef logic [1:0]            sel_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // Index of the last input; the counter wraps to 0 after it.
    localparam sel_t LAST_SEL = sel_t'(NUM_INPUTS - 1);

endpackage : mux_pkg

// File: rtl/mux_4_1_auto_sel_sel_counter.sv
// sel_counter
// Free-running modulo-4 select counter.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; clears cnt to 0
//   cnt   : current select index, advances by one every non-reset edge
module sel_counter
    import mux_pkg::*;
(
    input  logic clock,
    input  logic reset,
    output sel_t cnt
);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == LAST_SEL) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 2'd1;
        end
    end

endmodule : sel_counter

// File: rtl/mux_4_1_auto_sel.sv
// mux_4_1_auto_sel
// Serializes four parallel operand words onto one registered bus, one word
// per clock, in the order input_1, input_2, input_3, input_4, input_1, ...
// Ports:
//   clock           : rising-edge clock
//   reset           : synchronous, active-high; clears out, sel, valid and
//                     restarts the rotation at input_1
//   input_1..input_4: operand words (selected for index 0..3)
//   out             : registered selected word
//   sel             : index of the word currently on out (debug-visible
//                     rotation state)
//   valid           : out holds a sampled input rather than the reset value.
//                     There is no ready: the downstream stage must accept
//                     one word on every cycle that valid is high.
module mux_4_1_auto_sel
    import mux_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [WIDTH-1:0] input_3,
    input  logic [WIDTH-1:0] input_4,
    output logic [WIDTH-1:0] out,
    output sel_t             sel,
    output logic             valid
);

    sel_t             cnt;
    logic [WIDTH-1:0] mux_word;

    sel_counter u_sel_counter (
        .clock (clock),
        .reset (reset),
        .cnt   (cnt)
    );

    always_comb begin
        mux_word = '0;
        case (cnt)
            2'd0:    mux_word = input_1;
            2'd1:    mux_word = input_2;
            2'd2:    mux_word = input_3;
            default: mux_word = input_4;
        endcase
    end

    // sel registers the same cnt that chose mux_word, so sel always names
    // the word currently on out.
    always_ff @(posedge clock) begin
        if (reset) begin
            out   <= '0;
            sel   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= mux_word;
            sel   <= cnt;
            valid <= 1'b1;
        end
    end

endmodule : mux_4_1_auto_sel

// File: tb/tb_mux_4_1_auto_sel.sv
module tb_mux_4_1_auto_sel;

    localparam int W = 16;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_1 = '0, in_2 = '0, in_3 = '0, in_4 = '0;
    logic [W-1:0] out;
    logic [1:0]   sel;
    logic         valid;

    always #5 clock = ~clock;

    mux_4_1_auto_sel #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .input_1 (in_1),
        .input_2 (in_2),
        .input_3 (in_3),
        .input_4 (in_4),
        .out     (out),
        .sel     (sel),
        .valid   (valid)
    );

    // ---------------- counters / scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // Expected {out, sel, valid} per edge, packed into one word.
    logic [W+2:0] exp_q[$];

    // Reference model: number of non-reset edges since the last reset edge.
    int edges_since_reset = 0;

    function automatic logic [W-1:0] pick(input int idx);
        logic [W-1:0] words [4];
        words[0] = in_1; words[1] = in_2; words[2] = in_3; words[3] = in_4;
        return words[idx];
    endfunction

    // Called at a rising edge with the inputs as sampled there.
    task automatic model_edge();
        int idx;
        if (reset) begin
            edges_since_reset = 0;
            exp_q.push_back({{W{1'b0}}, 2'd0, 1'b0});
        end else begin
            idx = edges_since_reset % 4;
            exp_q.push_back({pick(idx), 2'(idx), 1'b1});
            edges_since_reset = edges_since_reset + 1;
        end
    endtask

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: model observes the edge, then outputs are sampled 1ns later.
    task automatic tick_and_check(input string tag);
        logic [W+2:0] e;
        @(posedge clock);
        model_edge();
        #1;
        e = exp_q.pop_front();
        check({tag, ".out"},   out,        e[W+2:3]);
        check({tag, ".sel"},   W'(sel),    W'(e[2:1]));
        check({tag, ".valid"}, W'(valid),  W'(e[0]));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic         rst;
        logic [W-1:0] i1, i2, i3, i4;
        logic [W-1:0] e_out;
        logic [1:0]   e_sel;
        logic         e_valid;
    } vec_t;

    vec_t vecs [12];

    initial begin
        // reset held for two edges
        vecs[0]  = '{1'b1, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 2'd0, 1'b0};
        // rotation after release
        vecs[2]  = '{1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0300, 2'd0, 1'b1};
        vecs[3]  = '{1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0200, 2'd1, 1'b1};
        // input_3 changed after the sel=1 edge
        vecs[4]  = '{1'b0, 16'h0300, 16'h0200, 16'hABCD, 16'h0000, 16'hABCD, 2'd2, 1'b1};
        vecs[5]  = '{1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 2'd3, 1'b1};
        vecs[6]  = '{1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0300, 2'd0, 1'b1};
        vecs[7]  = '{1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0200, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0100, 2'd2, 1'b1};
        // reset while sel = 2
        vecs[9]  = '{1'b1, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 2'd0, 1'b0};
        vecs[10] = '{1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0300, 2'd0, 1'b1};
        vecs[11] = '{1'b0, 16'h0300, 16'h0200, 16'h0100, 16'h0000, 16'h0200, 2'd1, 1'b1};
    end

    // ---------------- stimulus ----------------
    initial begin
        #1;
        for (int v = 0; v < 12; v++) begin
            reset = vecs[v].rst;
            in_1 = vecs[v].i1; in_2 = vecs[v].i2;
            in_3 = vecs[v].i3; in_4 = vecs[v].i4;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d.out", v),   out,       vecs[v].e_out);
            check($sformatf("vec%0d.sel", v),   W'(sel),   W'(vecs[v].e_sel));
            check($sformatf("vec%0d.valid", v), W'(valid), W'(vecs[v].e_valid));
        end

        // Wrap across many cycles: reset, then 12 edges = 3 full rotations.
        reset = 1'b1;
        in_1 = 16'h1111; in_2 = 16'h2222; in_3 = 16'h3333; in_4 = 16'h4444;
        tick_and_check("wrap_rst");
        reset = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clock);
            #1;
            check($sformatf("wrap%0d.out", e), out, W'((e % 4 + 1) * 16'h1111));
            check($sformatf("wrap%0d.sel", e), W'(sel), W'(e % 4));
        end

        // Reset glitch between edges must be ignored.
        reset = 1'b1;
        tick_and_check("glitch_rst");
        reset = 1'b0;
        tick_and_check("glitch_pre0");
        tick_and_check("glitch_pre1");
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        for (int g = 0; g < 6; g++) tick_and_check($sformatf("glitch_post%0d", g));

        // Randomized phase against the reference model.
        for (int r = 0; r < 300; r++) begin
            reset = ($urandom_range(0, 15) == 0);
            in_1 = W'($urandom); in_2 = W'($urandom);
            in_3 = W'($urandom); in_4 = W'($urandom);
            tick_and_check($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_4_1_auto_sel
